// File: rtl/xadc_temp_poller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xadc_pkg (package)
// Purpose  : Shared constants and types for the XADC temperature poller:
//            DRP register addresses, FSM state encoding, reset codes and the
//            Celsius-to-code conversion constants.
// Revision : 1.0 - initial release
// ============================================================================
package xadc_pkg;

    // XADC DRP status register addresses
    localparam logic [6:0] ADDR_TEMP    = 7'h00;  // current die temperature
    localparam logic [6:0] ADDR_MAXTEMP = 7'h20;  // max temperature since power-up

    // Output codes before any sample has been taken. All-ones reads as
    // "hottest possible", so downstream logic fails safe.
    localparam logic [11:0] TEMP_RESET_CODE     = 12'hFFF;
    localparam logic [11:0] TEMP_MAX_RESET_CODE = 12'h000;

    // code = (T_C + KELVIN_OFFSET) * CODE_PER_KELVIN, 12-bit XADC transfer
    // function. Used when deriving threshold parameters from Celsius.
    localparam real CODE_PER_KELVIN = 4096.0 / 503.975;
    localparam real KELVIN_OFFSET   = 273.15;

    // Sequencer states. REQ_M / WAIT_M are only reachable when the max
    // temperature read-back is built in.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_T  = 3'd1,
        S_WAIT_T = 3'd2,
        S_REQ_M  = 3'd3,
        S_WAIT_M = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xadc_temp_poller_if.sv
`default_nettype none
// ============================================================================
// Module   : xadc_temp_poller_if
// Purpose  : XADC dynamic reconfiguration port (DRP) bundle.
//            master : the poller (drives address/enable/write controls)
//            slave  : the XADC primitive (returns read data and ready)
// Signals  : drp_daddr[6:0], drp_den, drp_dwe, drp_di[15:0]  master -> slave
//            drp_do[15:0], drp_drdy                           slave -> master
// Revision : 1.0 - initial release
// ============================================================================
interface xadc_temp_poller_if;

    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr,
        output drp_den,
        output drp_dwe,
        output drp_di,
        input  drp_do,
        input  drp_drdy
    );

    modport slave (
        input  drp_daddr,
        input  drp_den,
        input  drp_dwe,
        input  drp_di,
        output drp_do,
        output drp_drdy
    );

endinterface
`default_nettype wire

// File: rtl/xadc_temp_poller_drp_read_port.sv
`default_nettype none
// ============================================================================
// Module   : drp_read_port
// Purpose  : Single DRP read engine. A start pulse latches the address and
//            issues a one-cycle enable; the engine then waits for the ready
//            strobe or gives up after TIMEOUT_CYCLES clocks (counted from
//            the enable edge).
// Ports    : clock, resetn          clock / synchronous active-low reset
//            i_start, i_addr        launch a read at i_addr
//            i_drp_drdy, i_drp_do   DRP ready strobe and read data
//            o_drp_den, o_drp_daddr DRP enable pulse and held address
//            o_done                 ready seen while waiting (same cycle)
//            o_timed_out            wait window expired (same cycle)
//            o_data                 read data, valid with o_done
// Revision : 1.0 - initial release
// ============================================================================
module drp_read_port #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    input  wire logic        i_start,
    input  wire logic [6:0]  i_addr,
    input  wire logic        i_drp_drdy,
    input  wire logic [15:0] i_drp_do,
    output logic             o_drp_den,
    output logic [6:0]       o_drp_daddr,
    output logic             o_done,
    output logic             o_timed_out,
    output logic [15:0]      o_data
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic               r_den;
    logic [6:0]         r_daddr;
    logic               r_wait;
    logic [c_cnt_w-1:0] r_cnt;

    // r_cnt holds (clocks since the enable edge - 1) while waiting, so the
    // give-up decision lands exactly TIMEOUT_CYCLES edges after the enable.
    // Ready in the enable cycle itself is not accepted (r_wait still low).
    assign o_done      = r_wait & i_drp_drdy;
    assign o_timed_out = r_wait & ~i_drp_drdy & (r_cnt == c_cnt_last);
    assign o_data      = i_drp_do;
    assign o_drp_den   = r_den;
    assign o_drp_daddr = r_daddr;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_den   <= 1'b0;
            r_daddr <= 7'h00;
            r_wait  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_den <= i_start;
            if (i_start) begin
                r_daddr <= i_addr;
                r_wait  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_den) begin
                r_wait <= 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end else if (r_wait) begin
                if (o_done || o_timed_out) begin
                    r_wait <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xadc_temp_poller.sv
`default_nettype none
// ============================================================================
// Module   : xadc_temp_poller
// Purpose  : Periodically reads the XADC on-die temperature over DRP and
//            presents it to the fan controller together with a fail-safe
//            alarm (OT pin, hysteretic high threshold, no sample yet, or
//            DRP timeout).
// Ports    : clock, resetn     board clock / synchronous active-low reset
//            xadc_ot           asynchronous XADC over-temperature pin
//            drp               DRP bundle (master side)
//            device_temp[11:0] last good temperature code
//            temp_valid        one-cycle pulse when device_temp updates
//            alarm             fan-full request
//            drp_timeout       sticky DRP timeout flag
//            device_temp_max   max temperature code (XADC_MAXTEMP_EN only)
// Config   : XADC_MAXTEMP_EN - also read DRP 7'h20 after each good
//            temperature read and present it as device_temp_max.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_temp_poller
    import xadc_pkg::*;
#(
    parameter int POLL_CYCLES    = 100000,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ALARM_HI       = 2910,
    parameter int ALARM_LO       = 2829
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    input  wire logic           xadc_ot,
    xadc_temp_poller_if.master  drp,
    output logic [11:0]         device_temp,
    output logic                temp_valid,
    output logic                alarm,
    output logic                drp_timeout
`ifdef XADC_MAXTEMP_EN
    ,
    output logic [11:0]         device_temp_max
`endif
);

    localparam int                   c_timer_w  = $clog2(POLL_CYCLES);
    localparam logic [c_timer_w-1:0] c_reload   = c_timer_w'(POLL_CYCLES - 1);
    localparam logic [11:0]          c_alarm_hi = 12'(ALARM_HI);
    localparam logic [11:0]          c_alarm_lo = 12'(ALARM_LO);

    state_t               r_state;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_have_sample;
    logic                 r_thr_alarm;
    logic                 r_ot_meta;
    logic                 r_ot_sync;
    logic [11:0]          r_device_temp;
    logic                 r_temp_valid;
    logic                 r_alarm;
    logic                 r_drp_timeout;
`ifdef XADC_MAXTEMP_EN
    logic [11:0]          r_device_temp_max;
`endif

    logic        w_start;
    logic [6:0]  w_addr;
    logic        w_done;
    logic        w_timed_out;
    logic [15:0] w_data;
    logic [11:0] w_code;
    logic [3:0]  w_unused_low_bits;
    logic        w_thr_next;
    logic        w_have_next;

    assign w_code            = w_data[15:4];
    assign w_unused_low_bits = w_data[3:0];

    drp_read_port #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_drp_read_port (
        .clock       (clock),
        .resetn      (resetn),
        .i_start     (w_start),
        .i_addr      (w_addr),
        .i_drp_drdy  (drp.drp_drdy),
        .i_drp_do    (drp.drp_do),
        .o_drp_den   (drp.drp_den),
        .o_drp_daddr (drp.drp_daddr),
        .o_done      (w_done),
        .o_timed_out (w_timed_out),
        .o_data      (w_data)
    );

    assign drp.drp_dwe = 1'b0;
    assign drp.drp_di  = 16'h0000;

    // Read launch and next-state of the alarm sources. The start decision
    // coincides with the FSM leaving IDLE (or WAIT_T for the max read), so
    // the engine's enable cycle is exactly the REQ state.
    always_comb begin
        w_start     = 1'b0;
        w_addr      = ADDR_TEMP;
        w_thr_next  = r_thr_alarm;
        w_have_next = r_have_sample;

        if (r_state == S_IDLE && r_timer == '0) begin
            w_start = 1'b1;
        end
`ifdef XADC_MAXTEMP_EN
        if (r_state == S_WAIT_T && w_done) begin
            w_start = 1'b1;
            w_addr  = ADDR_MAXTEMP;
        end
`endif

        if (r_state == S_WAIT_T) begin
            if (w_done) begin
                w_have_next = 1'b1;
                // Hysteresis: between LO (inclusive) and HI the flag holds.
                if (w_code >= c_alarm_hi) begin
                    w_thr_next = 1'b1;
                end else if (w_code < c_alarm_lo) begin
                    w_thr_next = 1'b0;
                end
            end else if (w_timed_out) begin
                w_have_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_have_sample <= 1'b0;
            r_thr_alarm   <= 1'b0;
            r_ot_meta     <= 1'b0;
            r_ot_sync     <= 1'b0;
            r_device_temp <= TEMP_RESET_CODE;
            r_temp_valid  <= 1'b0;
            r_alarm       <= 1'b1;
            r_drp_timeout <= 1'b0;
`ifdef XADC_MAXTEMP_EN
            r_device_temp_max <= TEMP_MAX_RESET_CODE;
`endif
        end else begin
            r_ot_meta     <= xadc_ot;
            r_ot_sync     <= r_ot_meta;
            r_have_sample <= w_have_next;
            r_thr_alarm   <= w_thr_next;
            // Built from next-state values so a new code or a timeout shows
            // on alarm at the same edge as device_temp / the failure.
            r_alarm       <= r_ot_sync | w_thr_next | ~w_have_next;
            r_temp_valid  <= 1'b0;

            // Free-running poll timer: reloads only on a read launch from
            // IDLE, so the period does not depend on DRP latency.
            if (r_state == S_IDLE && r_timer == '0) begin
                r_timer <= c_reload;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_timer == '0) begin
                        r_state <= S_REQ_T;
                    end
                end
                S_REQ_T: begin
                    r_state <= S_WAIT_T;
                end
                S_WAIT_T: begin
                    if (w_done) begin
                        r_device_temp <= w_code;
                        r_temp_valid  <= 1'b1;
`ifdef XADC_MAXTEMP_EN
                        r_state       <= S_REQ_M;
`else
                        r_state       <= S_IDLE;
`endif
                    end else if (w_timed_out) begin
                        r_drp_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
`ifdef XADC_MAXTEMP_EN
                S_REQ_M: begin
                    r_state <= S_WAIT_M;
                end
                S_WAIT_M: begin
                    if (w_done) begin
                        r_device_temp_max <= w_code;
                        r_state           <= S_IDLE;
                    end else if (w_timed_out) begin
                        // Current temperature is still good; only flag it.
                        r_drp_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign device_temp = r_device_temp;
    assign temp_valid  = r_temp_valid;
    assign alarm       = r_alarm;
    assign drp_timeout = r_drp_timeout;
`ifdef XADC_MAXTEMP_EN
    assign device_temp_max = r_device_temp_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xadc_temp_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_xadc_temp_poller
// Purpose  : Directed self-checking bench for xadc_temp_poller with a
//            behavioural XADC DRP responder (programmable latency/data).
//            Build with XADC_MAXTEMP_EN defined to cover the max read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_temp_poller;

    localparam int c_poll = 200;
    localparam int c_tmo  = 64;
`ifdef XADC_MAXTEMP_EN
    localparam int c_other_dens = 1;
`else
    localparam int c_other_dens = 0;
`endif

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        xadc_ot = 1'b0;
    logic [11:0] device_temp;
    logic        temp_valid;
    logic        alarm;
    logic        drp_timeout;
`ifdef XADC_MAXTEMP_EN
    logic [11:0] device_temp_max;
`endif

    xadc_temp_poller_if drp ();

    xadc_temp_poller #(
        .POLL_CYCLES    (c_poll),
        .TIMEOUT_CYCLES (c_tmo),
        .ALARM_HI       (2910),
        .ALARM_LO       (2829)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .xadc_ot     (xadc_ot),
        .drp         (drp),
        .device_temp (device_temp),
        .temp_valid  (temp_valid),
        .alarm       (alarm),
        .drp_timeout (drp_timeout)
`ifdef XADC_MAXTEMP_EN
        ,
        .device_temp_max (device_temp_max)
`endif
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_den20 = 0;

    // DRP responder controls
    int          m_latency = 3;
    bit          m_respond = 1'b1;
    logic [15:0] m_temp    = 16'hB5F0;
    logic [15:0] m_max     = 16'hA000;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (temp_valid) n_valid++;
        if (drp.drp_den && drp.drp_daddr == 7'h20) n_den20++;
    end

    // Behavioural XADC: sees den on a falling edge, answers m_latency
    // cycles later with a one-cycle drdy.
    initial begin
        logic [6:0] a;
        drp.drp_drdy = 1'b0;
        drp.drp_do   = 16'h0000;
        forever begin
            @(negedge clock);
            drp.drp_drdy = 1'b0;
            if (drp.drp_den && m_respond) begin
                a = drp.drp_daddr;
                repeat (m_latency) @(negedge clock);
                drp.drp_drdy = 1'b1;
                drp.drp_do   = (a == 7'h20) ? m_max : m_temp;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Waits for a den at address 'want'; counts other dens seen on the way.
    task automatic wait_den(input logic [6:0] want, input int budget,
                            output int at_cyc, output int n_other);
        int k;
        k       = 0;
        n_other = 0;
        @(negedge clock);
        while (!(drp.drp_den && drp.drp_daddr == want) && k < budget) begin
            if (drp.drp_den) n_other++;
            @(negedge clock);
            k++;
        end
        check_val("den_wait_bound", 32'(k < budget), 32'd1);
        at_cyc = cyc;
    endtask

    // Waits for temp_valid; returns alarm as it was one cycle earlier.
    task automatic wait_valid(input int budget, output logic prev_alarm);
        int k;
        k          = 0;
        prev_alarm = alarm;
        @(negedge clock);
        while (!temp_valid && k < budget) begin
            prev_alarm = alarm;
            @(negedge clock);
            k++;
        end
        check_val("valid_wait_bound", 32'(k < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_temp"},    32'(device_temp), 32'hFFF);
        check_val({tag, "_valid"},   32'(temp_valid), 32'd0);
        check_val({tag, "_alarm"},   32'(alarm), 32'd1);
        check_val({tag, "_timeout"}, 32'(drp_timeout), 32'd0);
        check_val({tag, "_den"},     32'(drp.drp_den), 32'd0);
        check_val({tag, "_daddr"},   32'(drp.drp_daddr), 32'd0);
`ifdef XADC_MAXTEMP_EN
        check_val({tag, "_tmax"},    32'(device_temp_max), 32'h000);
`endif
    endtask

    logic [11:0] codes   [6] = '{12'd2000, 12'd2900, 12'd2910, 12'd2850, 12'd2829, 12'd2828};
    logic        exp_alm [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int          lats    [5] = '{1, 7, 20, 33, 40};

    initial begin
        logic pa;
        logic prev_exp;
        int   c;
        int   c_prev;
        int   oth;
        int   k;
        int   nv0;

        // ---- 1: reset values, first read ----
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        check_val("dwe_tied", 32'(drp.drp_dwe), 32'd0);
        check_val("di_tied", 32'(drp.drp_di), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check_val("first_den", 32'(drp.drp_den), 32'd1);
        check_val("first_daddr", 32'(drp.drp_daddr), 32'h00);
        wait_valid(20, pa);
        check_val("t1_temp", 32'(device_temp), 32'hB5F);
        check_val("t1_alarm", 32'(alarm), 32'd1);
`ifdef XADC_MAXTEMP_EN
        check_val("t1_maxden", 32'(drp.drp_den && drp.drp_daddr == 7'h20), 32'd1);
`endif
        @(negedge clock);
        check_val("t1_single_valid", 32'(temp_valid), 32'd0);

        // ---- 2: threshold hysteresis ----
        prev_exp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_temp = {codes[i], 4'h0};
            wait_valid(c_poll + 80, pa);
            check_val("thr_temp", 32'(device_temp), 32'(codes[i]));
            check_val("thr_alarm", 32'(alarm), 32'(exp_alm[i]));
            check_val("thr_alarm_before", 32'(pa), 32'(prev_exp));
            prev_exp = exp_alm[i];
        end

        // ---- 3: DRP timeout ----
        m_respond = 1'b0;
        nv0 = n_valid;
        wait_den(7'h00, c_poll + 80, c, oth);
        k = 0;
        while (!drp_timeout && k < 200) begin
            @(negedge clock);
            k++;
        end
        check_val("tmo_latency", 32'(k), 32'(c_tmo));
        check_val("tmo_temp_kept", 32'(device_temp), 32'd2828);
        check_val("tmo_alarm", 32'(alarm), 32'd1);
        check_val("tmo_no_valid", 32'(n_valid), 32'(nv0));
        m_respond = 1'b1;
        m_temp    = {12'd2000, 4'h0};
        wait_valid(c_poll + 80, pa);
        check_val("tmo_recover_alarm", 32'(alarm), 32'd0);
        check_val("tmo_sticky", 32'(drp_timeout), 32'd1);

        // ---- 4: fixed poll period under varying DRP latency ----
        m_latency = lats[0];
        wait_den(7'h00, c_poll + 80, c_prev, oth);
        for (int i = 1; i < 5; i++) begin
            @(negedge clock);
            check_val("den_single", 32'(drp.drp_den), 32'd0);
            m_latency = lats[i];
            wait_den(7'h00, c_poll + 80, c, oth);
            check_val("den_period", 32'(c - c_prev), 32'(c_poll));
            check_val("den_per_read", 32'(oth), 32'(c_other_dens));
            c_prev = c;
        end

        // ---- 5: OT pin latency ----
        repeat (50) @(negedge clock);
        check_val("pre_ot_alarm", 32'(alarm), 32'd0);
        xadc_ot = 1'b1;
        k = 0;
        while (!alarm && k < 10) begin
            @(negedge clock);
            k++;
        end
        check_val("ot_rise_lat", 32'(k), 32'd3);
        repeat (5 - k) @(negedge clock);
        xadc_ot = 1'b0;
        k = 0;
        while (alarm && k < 10) begin
            @(negedge clock);
            k++;
        end
        check_val("ot_fall_lat", 32'(k), 32'd3);

        // ---- 5b: reset during WAIT_T, late drdy ----
        m_latency = 30;
        wait_den(7'h00, c_poll + 80, c, oth);
        nv0 = n_valid;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        repeat (40) @(negedge clock);
        check_val("rst_mid_no_valid", 32'(n_valid), 32'(nv0));
        check_reset_outputs("rst_mid");
        m_latency = 3;
        m_temp    = {12'd1000, 4'h0};
        resetn    = 1'b1;
        wait_valid(20, pa);
        check_val("post_rst_temp", 32'(device_temp), 32'd1000);
        check_val("post_rst_alarm", 32'(alarm), 32'd0);

        // ---- 6: max-temperature read ----
`ifdef XADC_MAXTEMP_EN
        m_temp = 16'h9000;
        m_max  = 16'hA000;
        wait_den(7'h00, c_poll + 80, c, oth);
        wait_valid(20, pa);
        check_val("m_temp", 32'(device_temp), 32'h900);
        check_val("m_den20", 32'(drp.drp_den && drp.drp_daddr == 7'h20), 32'd1);
        repeat (6) @(negedge clock);
        check_val("m_tmax", 32'(device_temp_max), 32'hA00);
`else
        check_val("no_addr20", 32'(n_den20), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
